hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/hex_display_scanner.sv | 77 +++++++
 tb/tb_hex_display_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display scanner with a double-buffered value so
// a refresh frame never mixes old and new digits.
module hex_display_scanner #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lead,
   output logic [3:0]  nibble,
   output logic [3:0]  an,
   output logic        ack
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      pend;
   logic             pend_blank;
   logic             pend_valid;
   logic [15:0]      disp;
   logic             disp_blank;
   logic             tick;
   logic             commit;
   logic             cur_blank;

   // A digit is dark when leading-zero suppression is on and it and every
   // more-significant digit are zero; the rightmost digit always shows.
   function automatic logic digit_blank(input logic [15:0] d,
                                        input logic        bl,
                                        input logic [1:0]  k);
      logic [15:0] upper;
      upper = d >> {k, 2'b00};
      return bl && (k != 2'd0) && (upper == 16'h0000);
   endfunction

   assign tick   = (cnt == CNT_LAST);
   assign commit = tick && (idx == 2'd3) && pend_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         pend       <= 16'h0000;
         pend_blank <= 1'b0;
         pend_valid <= 1'b0;
         disp       <= 16'h0000;
         disp_blank <= 1'b0;
         ack        <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         ack <= commit;
         if (commit) begin
            disp       <= pend;
            disp_blank <= pend_blank;
         end
         // A load in the commit cycle lands in pend after the old pend moved out.
         if (load) begin
            pend       <= value;
            pend_blank <= blank_lead;
         end
         pend_valid <= load | (pend_valid & ~commit);
      end
   end

   always_comb begin
      cur_blank = digit_blank(disp, disp_blank, idx);
      nibble    = disp[{idx, 2'b00} +: 4];
      an        = cur_blank ? 4'b1111 : ~(4'b0001 << idx);
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed and randomized bench for hex_display_scanner, compared every cycle
// against a frame-position model derived from elapsed cycles since reset.
module tb_hex_display_scanner;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0000;
   logic        blank_lead = 1'b0;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        ack;

   hex_display_scanner #(.REFRESH_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .value      (value),
      .blank_lead (blank_lead),
      .nibble     (nibble),
      .an         (an),
      .ack        (ack)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int ack_seen = 0;

   // model: elapsed cycles since reset fix the scan position arithmetically
   int unsigned t = 0;
   logic [15:0] m_pend = 16'h0, m_disp = 16'h0;
   logic        m_pbl = 1'b0, m_dbl = 1'b0, m_pv = 1'b0, m_ack = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic bl);
      int k;
      logic commit;
      logic [15:0] up;
      logic [3:0] onehot, e_an;
      logic e_blank;
      reset = rst; load = ld; value = v; blank_lead = bl;
      @(posedge clk);
      if (rst) begin
         t = 0; m_pend = 0; m_disp = 0; m_pbl = 0; m_dbl = 0; m_pv = 0; m_ack = 0;
      end else begin
         commit = (t % DIV == DIV - 1) && ((t / DIV) % 4 == 3) && m_pv;
         m_ack = commit;
         if (commit) begin
            m_disp = m_pend; m_dbl = m_pbl;
         end
         if (ld) begin
            m_pend = v; m_pbl = bl; m_pv = 1'b1;
         end else if (commit) begin
            m_pv = 1'b0;
         end
         t++;
      end
      #1;
      reset = 1'b0; load = 1'b0;
      k = (t / DIV) % 4;
      up = m_disp >> (4 * k);
      e_blank = m_dbl && (k != 0) && (up == 16'h0);
      onehot = 4'b0001 << k;
      e_an = e_blank ? 4'b1111 : ~onehot;
      chk("an", {12'h0, an}, {12'h0, e_an});
      chk("nibble", {12'h0, nibble}, {12'h0, up[3:0]});
      chk("ack", {15'h0, ack}, {15'h0, m_ack});
      if (ack === 1'b1) ack_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic run_until_ack(input int maxc, output bit found);
      found = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         if (ack === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic idle_until_phase(input int unsigned ph);
      for (int i = 0; i < 16 && (t % 16) != ph; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      bit found;
      int ones;
      logic [3:0] tbl_a[4];
      logic [3:0] tbl_b[4];
      logic [3:0] tbl_c[4];
      logic [15:0] rv;

      // reset and free-run
      step(1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b1, 16'hFFFF, 1'b1);
      chk("reset_an", {12'h0, an}, 16'h000E);
      chk("reset_nibble", {12'h0, nibble}, 16'h0000);
      ack_seen = 0;
      idle(32);
      chk("freerun_acks", ack_seen[15:0], 16'd0);

      // A3F0 loaded mid-frame
      idle_until_phase(6);
      step(1'b0, 1'b1, 16'hA3F0, 1'b0);
      ack_seen = 0;
      run_until_ack(40, found);
      chk("a3f0_ack_found", {15'h0, found}, 16'd1);
      tbl_a = '{4'h0, 4'hF, 4'h3, 4'hA};
      chk("a3f0_nib", {12'h0, nibble}, {12'h0, tbl_a[0]});
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         chk("a3f0_nib", {12'h0, nibble}, {12'h0, tbl_a[i / 4]});
      end
      chk("a3f0_acks", ack_seen[15:0], 16'd1);

      // leading-zero blanking
      step(1'b0, 1'b1, 16'h0005, 1'b1);
      run_until_ack(40, found);
      chk("blank_ack_found", {15'h0, found}, 16'd1);
      chk("blank_d0_an", {12'h0, an}, 16'h000E);
      chk("blank_d0_nib", {12'h0, nibble}, 16'h0005);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         chk("blank_an", {12'h0, an}, (i < 4) ? 16'h000E : 16'h000F);
      end

      // latest load wins, single ack
      idle_until_phase(2);
      ack_seen = 0;
      ones = 0;
      step(1'b0, 1'b1, 16'h1111, 1'b0);
      step(1'b0, 1'b1, 16'h2222, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         if (nibble === 4'h1) ones++;
      end
      chk("latest_acks", ack_seen[15:0], 16'd1);
      chk("latest_no_1111", ones[15:0], 16'd0);
      chk("latest_shows_2", {12'h0, nibble}, 16'h0002);

      // load coinciding with commit
      idle_until_phase(4);
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      idle_until_phase(15);
      step(1'b0, 1'b1, 16'hBEEF, 1'b0);
      chk("coinc_ack1", {15'h0, ack}, 16'd1);
      tbl_b = '{4'h4, 4'h3, 4'h2, 4'h1};
      chk("coinc_1234", {12'h0, nibble}, {12'h0, tbl_b[0]});
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         chk("coinc_1234", {12'h0, nibble}, {12'h0, tbl_b[i / 4]});
      end
      tbl_c = '{4'hF, 4'hE, 4'hE, 4'hB};
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("coinc_ack2", {15'h0, ack}, 16'd1);
      chk("coinc_beef", {12'h0, nibble}, {12'h0, tbl_c[0]});
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         chk("coinc_beef", {12'h0, nibble}, {12'h0, tbl_c[i / 4]});
      end

      // reset discards a pending value
      idle_until_phase(0);
      ack_seen = 0;
      step(1'b0, 1'b1, 16'hFFFF, 1'b0);
      idle(3);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("rst_pend_an", {12'h0, an}, 16'h000E);
      chk("rst_pend_nib", {12'h0, nibble}, 16'h0000);
      idle(40);
      chk("rst_pend_acks", ack_seen[15:0], 16'd0);

      // randomized traffic with occasional reset
      for (int i = 0; i < 1500; i++) begin
         rv = 16'($urandom) >> $urandom_range(0, 16);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0), rv, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
